// File: rtl/key_debounce_pulse_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared constants and helpers for the push-button front-end.
//   clog2          : ceiling log2, never less than 1, used for counter widths
//   idle_level     : pin level of a released button for a given polarity
//   DEB_20MS_12M   : 20 ms debounce window at 12 MHz
//   LONG_1S_12M    : 1 s long-press window at 12 MHz
// ---------------------------------------------------------------------------
package key_pkg;

  localparam int DEB_20MS_12M = 240000;
  localparam int LONG_1S_12M  = 12000000;

  // Width needed to hold the values 0 .. v-1. A counter of this width only
  // ever reaches v-1, so it cannot wrap.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

  // Released level on the pin: high for active-low buttons, low otherwise.
  function automatic logic idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/key_debounce_pulse_if.sv
// ---------------------------------------------------------------------------
// key_debounce_pulse_if
// Groups the button pins and the debounced/pulse outputs of the front-end.
//   btn_in        : raw asynchronous button pins        (master -> slave)
//   btn_deb       : debounced level, pin polarity        (slave -> master)
//   press_pulse   : 1-cycle pulse on entering pressed    (slave -> master)
//   release_pulse : 1-cycle pulse on entering released   (slave -> master)
//   long_pulse    : 1-cycle pulse after a long hold      (slave -> master)
// The debouncer is the slave; the board pins / downstream stage the master.
// ---------------------------------------------------------------------------
interface key_debounce_pulse_if #(
  parameter int BTN_WIDTH = 1
);

  logic [BTN_WIDTH-1:0] btn_in;
  logic [BTN_WIDTH-1:0] btn_deb;
  logic [BTN_WIDTH-1:0] press_pulse;
  logic [BTN_WIDTH-1:0] release_pulse;
  logic [BTN_WIDTH-1:0] long_pulse;

  modport master (
    output btn_in,
    input  btn_deb,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  btn_in,
    output btn_deb,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );

endinterface

// File: rtl/key_debounce_pulse_bit.sv
// ---------------------------------------------------------------------------
// key_debounce_bit
// One button bit: two-FF synchroniser, debounce counter, long-press hold
// counter and registered press/release/long pulses.
// Ports:
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   btn_i     : raw asynchronous pin
//   deb_o     : debounced level in pin polarity
//   press_o   : 1-cycle pulse on the edge deb_o becomes pressed
//   release_o : 1-cycle pulse on the edge deb_o becomes released
//   long_o    : 1-cycle pulse once a press has been held LONG_CYCLES
// ---------------------------------------------------------------------------
module key_debounce_bit
  import key_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_20MS_12M,
  parameter int LONG_CYCLES = LONG_1S_12M,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic deb_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic IDLE    = idle_level(ACTIVE_LOW);
  localparam logic PRESSED = ~IDLE;

  localparam int DEB_W  = clog2(DEB_CYCLES);
  localparam int HOLD_W = clog2(LONG_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              s1_q, s2_q;
  logic              deb_q, deb_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_done_q, long_done_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  // Debounce: any sample that matches the accepted level restarts the
  // window, so a glitch shorter than DEB_CYCLES is simply lost.
  always_comb begin
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_LAST) begin
      deb_d = s2_q;
      cnt_d = '0;
      if (s2_q == PRESSED) begin
        press_d = 1'b1;
      end else begin
        release_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Long press: counts on the registered debounced level, so the first
  // count lands the cycle after press_o and long_o fires exactly
  // LONG_CYCLES edges after it. long_done freezes the counter until release,
  // which gives one long pulse per press and no auto-repeat.
  always_comb begin
    hold_d      = hold_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (deb_q != PRESSED) begin
      hold_d      = '0;
      long_done_d = 1'b0;
    end else if (!long_done_q) begin
      if (hold_q == HOLD_LAST) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q        <= IDLE;
      s2_q        <= IDLE;
      deb_q       <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      s1_q        <= btn_i;
      s2_q        <= s1_q;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign deb_o     = deb_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

  // Press and release come from opposite branches of one decision.
  assert property (@(posedge clk) disable iff (!rst_n) !(press_q && release_q));
  // A long pulse can only follow a held, already-accepted press.
  assert property (@(posedge clk) disable iff (!rst_n) long_q |-> (deb_q == PRESSED));

endmodule

// File: rtl/key_debounce_pulse.sv
// ---------------------------------------------------------------------------
// key_debounce_pulse
// Push-button front-end: per-bit synchronise, debounce and pulse generation.
// Ports:
//   clk    : 12 MHz system clock
//   rst_n  : synchronous active-low reset
//   btn_if : slave side of key_debounce_pulse_if
//            (btn_in in; btn_deb, press_pulse, release_pulse, long_pulse out)
// Each bit is a fully independent key_debounce_bit; simultaneous events on
// different bits appear in the same cycle.
// ---------------------------------------------------------------------------
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int BTN_WIDTH   = 1,
  parameter int DEB_CYCLES  = DEB_20MS_12M,
  parameter int LONG_CYCLES = LONG_1S_12M,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  key_debounce_pulse_if.slave btn_if
);

  logic [BTN_WIDTH-1:0] deb_vec;
  logic [BTN_WIDTH-1:0] press_vec;
  logic [BTN_WIDTH-1:0] release_vec;
  logic [BTN_WIDTH-1:0] long_vec;

  generate
    for (genvar gi = 0; gi < BTN_WIDTH; gi++) begin : g_bit
      key_debounce_bit #(
        .DEB_CYCLES  (DEB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES),
        .ACTIVE_LOW  (ACTIVE_LOW)
      ) u_bit (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn_if.btn_in[gi]),
        .deb_o     (deb_vec[gi]),
        .press_o   (press_vec[gi]),
        .release_o (release_vec[gi]),
        .long_o    (long_vec[gi])
      );
    end
  endgenerate

  assign btn_if.btn_deb       = deb_vec;
  assign btn_if.press_pulse   = press_vec;
  assign btn_if.release_pulse = release_vec;
  assign btn_if.long_pulse    = long_vec;

endmodule

// File: tb/tb_key_debounce_pulse.sv
`timescale 1ns/1ps
// Bench for key_debounce_pulse with DEB_CYCLES=4, LONG_CYCLES=10,
// ACTIVE_LOW=1, BTN_WIDTH=2. The stimulus process drives pins and queues
// the pulse events it expects (edge number plus all outputs); a monitor
// pops one entry each cycle any pulse is high and compares it.
module tb_key_debounce_pulse;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;          // number of rising edges seen so far
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_debounce_pulse_if #(.BTN_WIDTH(2)) bif ();

  key_debounce_pulse #(
    .BTN_WIDTH   (2),
    .DEB_CYCLES  (4),
    .LONG_CYCLES (10),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_if (bif)
  );

  typedef struct {
    int         cyc;
    logic [1:0] deb;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
  } ev_t;

  ev_t exp_q[$];

  function automatic void expect_ev(int c, logic [1:0] d, logic [1:0] p,
                                    logic [1:0] r, logic [1:0] l);
    ev_t e;
    e.cyc = c; e.deb = d; e.press = p; e.rel = r; e.lng = l;
    exp_q.push_back(e);
  endfunction

  // Called only at a falling edge: the pin value is sampled on the next
  // rising edge, whose number is returned in t.
  task automatic drive(input logic [1:0] v, output int t);
    bif.btn_in = v;
    t = cyc + 1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_quiet(input string name, input logic [1:0] deb_req);
    total++;
    if (bif.btn_deb !== deb_req || bif.press_pulse !== 2'b00 ||
        bif.release_pulse !== 2'b00 || bif.long_pulse !== 2'b00) begin
      bad++;
      $display("FAIL %s cyc=%0d deb=%b press=%b rel=%b long=%b required deb=%b pulses=00",
               name, cyc, bif.btn_deb, bif.press_pulse, bif.release_pulse,
               bif.long_pulse, deb_req);
    end else begin
      $display("ok   %s cyc=%0d deb=%b", name, cyc, bif.btn_deb);
    end
  endtask

  // Monitor: every cycle a pulse is visible, match it to the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if ((bif.press_pulse | bif.release_pulse | bif.long_pulse) == 2'b00) continue;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d deb=%b press=%b rel=%b long=%b required no pulse",
                 cyc, bif.btn_deb, bif.press_pulse, bif.release_pulse, bif.long_pulse);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || bif.btn_deb !== e.deb || bif.press_pulse !== e.press ||
            bif.release_pulse !== e.rel || bif.long_pulse !== e.lng) begin
          bad++;
          $display("FAIL event cyc=%0d deb=%b press=%b rel=%b long=%b required cyc=%0d deb=%b press=%b rel=%b long=%b",
                   cyc, bif.btn_deb, bif.press_pulse, bif.release_pulse, bif.long_pulse,
                   e.cyc, e.deb, e.press, e.rel, e.lng);
        end else begin
          $display("ok   event cyc=%0d deb=%b press=%b rel=%b long=%b",
                   cyc, bif.btn_deb, bif.press_pulse, bif.release_pulse, bif.long_pulse);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    bif.btn_in = 2'b00;
    rst_n = 1'b0;

    // Reset with both pins low (pressed): outputs held idle.
    repeat (3) begin
      @(negedge clk);
      check_quiet("reset_hold", 2'b11);
    end
    rst_n = 1'b1;
    t = cyc + 1;
    expect_ev(t + 5,  2'b00, 2'b11, 2'b00, 2'b00);
    expect_ev(t + 15, 2'b00, 2'b00, 2'b00, 2'b11);
    @(negedge clk);
    check_quiet("post_reset_quiet", 2'b11);
    wait_cyc(t + 20);
    drive(2'b11, t2);
    expect_ev(t2 + 5, 2'b11, 2'b00, 2'b11, 2'b00);
    wait_cyc(t2 + 10);
    check_quiet("idle_after_reset_case", 2'b11);

    // Clean press on bit0, held well past the long pulse.
    drive(2'b10, t);
    expect_ev(t + 5,  2'b10, 2'b01, 2'b00, 2'b00);
    expect_ev(t + 15, 2'b10, 2'b00, 2'b00, 2'b01);
    wait_cyc(t + 40);
    check_quiet("clean_held", 2'b10);
    drive(2'b11, t2);
    expect_ev(t2 + 5, 2'b11, 2'b00, 2'b01, 2'b00);
    wait_cyc(t2 + 10);
    check_quiet("idle_after_clean", 2'b11);

    // Bounce 0,1,0,1 then stable 0 on bit0.
    drive(2'b10, t);
    @(negedge clk); drive(2'b11, t);
    @(negedge clk); drive(2'b10, t);
    @(negedge clk); drive(2'b11, t);
    @(negedge clk); drive(2'b10, t);
    expect_ev(t + 5,  2'b10, 2'b01, 2'b00, 2'b00);
    expect_ev(t + 15, 2'b10, 2'b00, 2'b00, 2'b01);
    wait_cyc(t + 20);
    drive(2'b11, t2);
    expect_ev(t2 + 5, 2'b11, 2'b00, 2'b01, 2'b00);
    wait_cyc(t2 + 10);
    check_quiet("idle_after_bounce", 2'b11);

    // Short press: 8 cycles low, released before the long window.
    drive(2'b10, t);
    expect_ev(t + 5,  2'b10, 2'b01, 2'b00, 2'b00);
    expect_ev(t + 13, 2'b11, 2'b00, 2'b01, 2'b00);
    wait_cyc(t + 7);
    drive(2'b11, t2);
    wait_cyc(t + 30);
    check_quiet("idle_after_short", 2'b11);

    // Simultaneous press, then release only bit1.
    drive(2'b00, t);
    expect_ev(t + 5, 2'b00, 2'b11, 2'b00, 2'b00);
    wait_cyc(t + 5);
    drive(2'b10, t2);
    expect_ev(t2 + 5, 2'b10, 2'b00, 2'b10, 2'b00);
    expect_ev(t + 15, 2'b10, 2'b00, 2'b00, 2'b01);
    wait_cyc(t + 25);
    drive(2'b11, t2);
    expect_ev(t2 + 5, 2'b11, 2'b00, 2'b01, 2'b00);
    wait_cyc(t2 + 10);
    check_quiet("idle_after_simul", 2'b11);

    // Reset while bit0 is held with hold counter at 7.
    drive(2'b10, t);
    expect_ev(t + 5, 2'b10, 2'b01, 2'b00, 2'b00);
    wait_cyc(t + 12);
    rst_n = 1'b0;
    @(negedge clk);
    check_quiet("mid_hold_reset", 2'b11);
    rst_n = 1'b1;
    t2 = cyc + 1;
    expect_ev(t2 + 5,  2'b10, 2'b01, 2'b00, 2'b00);
    expect_ev(t2 + 15, 2'b10, 2'b00, 2'b00, 2'b01);
    @(negedge clk);
    check_quiet("after_reset_quiet", 2'b11);
    wait_cyc(t2 + 25);
    drive(2'b11, t);
    expect_ev(t + 5, 2'b11, 2'b00, 2'b01, 2'b00);
    wait_cyc(t + 10);
    check_quiet("idle_final", 2'b11);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events pending=%0d required 0 (next cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
